// File: rtl/handshake_pkg.sv
// Shared arbitration types and the round-robin pick function.
// Exports N_DEFAULT, WIDTH_DEFAULT, gidx_t and rr_next().
package handshake_pkg;

  localparam int N_DEFAULT     = 3;
  localparam int WIDTH_DEFAULT = 4;
  localparam int MAX_N         = 8;
  localparam int GIDX_W        = 3;

  typedef logic [GIDX_W-1:0] gidx_t;

  typedef struct packed {
    logic  hit;
    gidx_t idx;
  } rr_pick_t;

  // Scan upward from last+1, wrapping at n; first set bit wins.
  function automatic rr_pick_t rr_next(
    input gidx_t            last,
    input logic [MAX_N-1:0] valid_vec,
    input int               n
  );
    rr_pick_t p;
    int       j;
    p = '0;
    for (int k = 1; k <= MAX_N; k++) begin
      j = (int'(last) + k) % n;
      if (k <= n && !p.hit && valid_vec[j]) begin
        p.hit = 1'b1;
        p.idx = gidx_t'(j);
      end
    end
    return p;
  endfunction

endpackage

// File: rtl/rr_grant.sv
// Combinational round-robin priority encoder.
// Ports: valid, last -> grant (one-hot), idx, hit.
module rr_grant
  import handshake_pkg::*;
#(
  parameter int N    = N_DEFAULT,
  parameter int ID_W = 2
) (
  input  logic [N-1:0]    valid,
  input  logic [ID_W-1:0] last,
  output logic [N-1:0]    grant,
  output logic [ID_W-1:0] idx,
  output logic            hit
);

  logic [MAX_N-1:0] vv;
  rr_pick_t         pick;

  always_comb begin
    vv         = '0;
    vv[N-1:0]  = valid;
    pick       = rr_next(gidx_t'(last), vv, N);
    hit        = pick.hit;
    idx        = ID_W'(pick.idx);
    grant      = '0;
    for (int i = 0; i < N; i++) begin
      grant[i] = pick.hit && (pick.idx == gidx_t'(i));
    end
  end

endmodule

// File: rtl/handshake_rr_arbiter.sv
// Round-robin merge of N ready/valid requesters onto one registered channel.
// Ports: CLK, RESET, in_valid/in_ready/in_data, out_valid/out_ready/out_data, out_id, xfer_count.
module handshake_rr_arbiter
  import handshake_pkg::*;
#(
  parameter int N     = N_DEFAULT,
  parameter int WIDTH = WIDTH_DEFAULT,
  parameter int ID_W  = 2,
  parameter int CNT_W = 8
) (
  input  logic               CLK,
  input  logic               RESET,
  input  logic [N-1:0]       in_valid,
  output logic [N-1:0]       in_ready,
  input  logic [N*WIDTH-1:0] in_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   out_data,
  output logic [ID_W-1:0]    out_id,
  output logic [CNT_W-1:0]   xfer_count
);

  typedef enum logic {EMPTY, FULL} state_t;

  state_t          state;
  logic [ID_W-1:0] last_grant;
  logic [ID_W-1:0] g_idx;
  logic [N-1:0]    g_hot;
  logic            g_hit;
  logic            accept;
  logic            up_hs;
  logic            dn_hs;

  rr_grant #(.N(N), .ID_W(ID_W)) u_grant (
    .valid (in_valid),
    .last  (last_grant),
    .grant (g_hot),
    .idx   (g_idx),
    .hit   (g_hit)
  );

  assign out_valid = (state == FULL);
  assign accept    = ~out_valid | out_ready;

  // Ready is suppressed while RESET is high so nothing is offered
  // a handshake that the reset would then discard.
  assign in_ready = (accept & g_hit & ~RESET) ? g_hot : '0;
  assign up_hs    = |(in_valid & in_ready);
  assign dn_hs    = out_valid & out_ready;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state      <= EMPTY;
      out_data   <= '0;
      out_id     <= '0;
      xfer_count <= '0;
      last_grant <= ID_W'(N - 1);
    end else begin
      if (up_hs) begin
        state      <= FULL;
        out_data   <= in_data[g_idx*WIDTH +: WIDTH];
        out_id     <= g_idx;
        last_grant <= g_idx;
      end else if (dn_hs) begin
        state <= EMPTY;
      end
      if (dn_hs) begin
        xfer_count <= xfer_count + 1'b1;
      end
    end
  end

endmodule
